// File: rtl/core_wb_arbiter.sv
// core_wb_arbiter: shares one pipelined Wishbone master port between two
// enable/busy requesters. Requester 0 is the memory controller path and
// requester 1 is the debug/DMA path. Grants alternate round-robin, and only
// one transfer is in flight at a time. A bus timeout aborts any transfer
// whose acknowledge never arrives.
module core_wb_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        req0_enable,
    input  logic        req0_writeEnable,
    input  logic [27:0] req0_address,
    input  logic [3:0]  req0_byteSelect,
    input  logic [31:0] req0_dataWrite,
    output logic [31:0] req0_dataRead,
    output logic        req0_busy,
    output logic        req0_error,

    input  logic        req1_enable,
    input  logic        req1_writeEnable,
    input  logic [27:0] req1_address,
    input  logic [3:0]  req1_byteSelect,
    input  logic [31:0] req1_dataWrite,
    output logic [31:0] req1_dataRead,
    output logic        req1_busy,
    output logic        req1_error,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [27:0] wb_adr_o,
    output logic [31:0] wb_data_o,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,
    input  logic        wb_error_i,
    input  logic [31:0] wb_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_ACK,
        DONE
    } state_t;

    // The counter aborts on the edge that ends the Nth bus cycle, so it
    // compares against N-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic        owner;
    logic        last_owner;
    logic [7:0]  timeout_count;

    logic        grant_valid;
    logic        grant_sel;
    logic        owner_enable;
    logic        in_transfer;
    logic        response_edge;
    logic        abort_edge;
    logic        finish;
    logic        finish_error;
    logic [31:0] finish_data;

    // Arbitration, plus decoding whether this edge completes the transfer.
    // A real ack/error beats a simultaneous timeout.
    always_comb begin
        grant_valid   = req0_enable | req1_enable;
        grant_sel     = (req0_enable & req1_enable) ? ~last_owner : req1_enable;
        owner_enable  = owner ? req1_enable : req0_enable;
        in_transfer   = (state == REQUEST) || (state == WAIT_ACK);
        response_edge = ((state == REQUEST) && !wb_stall_i && (wb_ack_i || wb_error_i))
                     || ((state == WAIT_ACK) && (wb_ack_i || wb_error_i));
        abort_edge    = in_transfer && !response_edge && (timeout_count == TIMEOUT_LAST);
        finish        = response_edge || abort_edge;
        finish_error  = abort_edge || (response_edge && wb_error_i);
        finish_data   = finish_error ? 32'h0 : wb_data_i;
    end

    // Busy drops only in the owning requester's DONE cycle.
    always_comb begin
        req0_busy = req0_enable & ~((state == DONE) & (owner == 1'b0));
        req1_busy = req1_enable & ~((state == DONE) & (owner == 1'b1));
    end

    // Main transfer FSM with registered bus controls and per-requester results.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_owner    <= 1'b1;
            timeout_count <= 8'd0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_we_o       <= 1'b0;
            wb_sel_o      <= 4'd0;
            wb_adr_o      <= 28'd0;
            wb_data_o     <= 32'd0;
            req0_dataRead <= 32'd0;
            req1_dataRead <= 32'd0;
            req0_error    <= 1'b0;
            req1_error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner         <= grant_sel;
                        wb_adr_o      <= grant_sel ? req1_address     : req0_address;
                        wb_sel_o      <= grant_sel ? req1_byteSelect  : req0_byteSelect;
                        wb_we_o       <= grant_sel ? req1_writeEnable : req0_writeEnable;
                        wb_data_o     <= grant_sel ? req1_dataWrite   : req0_dataWrite;
                        wb_cyc_o      <= 1'b1;
                        wb_stb_o      <= 1'b1;
                        timeout_count <= 8'd0;
                        state         <= REQUEST;
                    end
                end
                REQUEST, WAIT_ACK: begin
                    if (finish) begin
                        state      <= DONE;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        last_owner <= owner;
                        if (owner_enable) begin
                            if (owner) begin
                                req1_dataRead <= finish_data;
                                req1_error    <= finish_error;
                            end else begin
                                req0_dataRead <= finish_data;
                                req0_error    <= finish_error;
                            end
                        end
                    end else begin
                        timeout_count <= timeout_count + 8'd1;
                        if ((state == REQUEST) && !wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= WAIT_ACK;
                        end
                    end
                end
                DONE: begin
                    req0_error <= 1'b0;
                    req1_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_wb_arbiter.sv
// tb_core_wb_arbiter: directed bench for core_wb_arbiter built with an
// 8-cycle timeout. Inputs change 1 time unit after each rising edge, and
// outputs are sampled at that same point.
module tb_core_wb_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        req0_enable, req0_writeEnable;
    logic [27:0] req0_address;
    logic [3:0]  req0_byteSelect;
    logic [31:0] req0_dataWrite, req0_dataRead;
    logic        req0_busy, req0_error;
    logic        req1_enable, req1_writeEnable;
    logic [27:0] req1_address;
    logic [3:0]  req1_byteSelect;
    logic [31:0] req1_dataWrite, req1_dataRead;
    logic        req1_busy, req1_error;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [27:0] wb_adr_o;
    logic [31:0] wb_data_o;
    logic        wb_ack_i, wb_stall_i, wb_error_i;
    logic [31:0] wb_data_i;

    int testsRun = 0;
    int failCount = 0;

    core_wb_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req0_enable(req0_enable), .req0_writeEnable(req0_writeEnable),
        .req0_address(req0_address), .req0_byteSelect(req0_byteSelect),
        .req0_dataWrite(req0_dataWrite), .req0_dataRead(req0_dataRead),
        .req0_busy(req0_busy), .req0_error(req0_error),
        .req1_enable(req1_enable), .req1_writeEnable(req1_writeEnable),
        .req1_address(req1_address), .req1_byteSelect(req1_byteSelect),
        .req1_dataWrite(req1_dataWrite), .req1_dataRead(req1_dataRead),
        .req1_busy(req1_busy), .req1_error(req1_error),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_data_o(wb_data_o),
        .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i), .wb_error_i(wb_error_i),
        .wb_data_i(wb_data_i)
    );

    // Free-running 10-unit clock.
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic advanceCycle;
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int n, input logic en, input logic we,
                                 input logic [27:0] adr, input logic [3:0] sel,
                                 input logic [31:0] data);
        if (n == 0) begin
            req0_enable = en; req0_writeEnable = we; req0_address = adr;
            req0_byteSelect = sel; req0_dataWrite = data;
        end else begin
            req1_enable = en; req1_writeEnable = we; req1_address = adr;
            req1_byteSelect = sel; req1_dataWrite = data;
        end
    endtask

    // Directed sequence covering every scenario in order.
    initial begin
        wb_rst_i = 1'b1;
        applyStimulus(0, 1'b0, 1'b0, 28'h0, 4'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 28'h0, 4'h0, 32'h0);
        wb_ack_i = 1'b0; wb_stall_i = 1'b0; wb_error_i = 1'b0; wb_data_i = 32'h0;
        advanceCycle;
        advanceCycle;

        // Reset state
        checkOutput("rst_cyc", 32'(wb_cyc_o), 32'h0);
        checkOutput("rst_stb", 32'(wb_stb_o), 32'h0);
        checkOutput("rst_adr", 32'(wb_adr_o), 32'h0);
        checkOutput("rst_dr0", req0_dataRead, 32'h0);
        checkOutput("rst_err1", 32'(req1_error), 32'h0);
        req1_enable = 1'b1;
        #1;
        checkOutput("rst_busy_follows", 32'(req1_busy), 32'h1);
        req1_enable = 1'b0;
        wb_rst_i = 1'b0;
        advanceCycle;

        // Single read by requester 0 at minimum latency
        applyStimulus(0, 1'b1, 1'b0, 28'h0001000, 4'hF, 32'h0);
        advanceCycle;
        checkOutput("rd_c1_stb", 32'(wb_stb_o), 32'h1);
        checkOutput("rd_c1_cyc", 32'(wb_cyc_o), 32'h1);
        checkOutput("rd_c1_adr", 32'(wb_adr_o), 32'h0001000);
        checkOutput("rd_c1_we", 32'(wb_we_o), 32'h0);
        checkOutput("rd_c1_busy", 32'(req0_busy), 32'h1);
        advanceCycle;
        checkOutput("rd_c2_stb", 32'(wb_stb_o), 32'h0);
        checkOutput("rd_c2_busy", 32'(req0_busy), 32'h1);
        wb_ack_i = 1'b1; wb_data_i = 32'hDEADBEEF;
        advanceCycle;
        checkOutput("rd_c3_busy", 32'(req0_busy), 32'h0);
        checkOutput("rd_c3_data", req0_dataRead, 32'hDEADBEEF);
        checkOutput("rd_c3_err", 32'(req0_error), 32'h0);
        checkOutput("rd_c3_cyc", 32'(wb_cyc_o), 32'h0);
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        advanceCycle;
        checkOutput("rd_c4_busy", 32'(req0_busy), 32'h1);
        checkOutput("rd_c4_cyc", 32'(wb_cyc_o), 32'h0);
        req0_enable = 1'b0;
        advanceCycle;

        // Round-robin from reset with both requesters always asking
        wb_rst_i = 1'b1;
        advanceCycle;
        wb_rst_i = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 28'h00000A0, 4'hF, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 28'h00000B0, 4'hF, 32'h0);
        for (int i = 0; i < 8; i++) begin
            advanceCycle;
            checkOutput($sformatf("rr%0d_adr", i), 32'(wb_adr_o),
                        (i % 2 == 0) ? 32'hA0 : 32'hB0);
            checkOutput($sformatf("rr%0d_waiter_busy", i),
                        32'((i % 2 == 0) ? req1_busy : req0_busy), 32'h1);
            advanceCycle;
            wb_ack_i = 1'b1; wb_data_i = 32'hC0DE0000 + 32'(i);
            advanceCycle;
            checkOutput($sformatf("rr%0d_owner_busy", i),
                        32'((i % 2 == 0) ? req0_busy : req1_busy), 32'h0);
            checkOutput($sformatf("rr%0d_waiter_busy_done", i),
                        32'((i % 2 == 0) ? req1_busy : req0_busy), 32'h1);
            checkOutput($sformatf("rr%0d_data", i),
                        (i % 2 == 0) ? req0_dataRead : req1_dataRead,
                        32'hC0DE0000 + 32'(i));
            wb_ack_i = 1'b0; wb_data_i = 32'h0;
            advanceCycle;
        end
        req0_enable = 1'b0; req1_enable = 1'b0;
        advanceCycle;

        // Stalled write by requester 1
        applyStimulus(1, 1'b1, 1'b1, 28'h0ABCDEF, 4'h3, 32'h12345678);
        wb_stall_i = 1'b1;
        advanceCycle;
        checkOutput("wr_we", 32'(wb_we_o), 32'h1);
        checkOutput("wr_data", wb_data_o, 32'h12345678);
        checkOutput("wr_sel", 32'(wb_sel_o), 32'h3);
        for (int k = 2; k <= 4; k++) begin
            advanceCycle;
            checkOutput($sformatf("wr_stb_c%0d", k), 32'(wb_stb_o), 32'h1);
        end
        wb_stall_i = 1'b0;
        advanceCycle;
        checkOutput("wr_stb_c5", 32'(wb_stb_o), 32'h0);
        checkOutput("wr_cyc_c5", 32'(wb_cyc_o), 32'h1);
        wb_ack_i = 1'b1; wb_data_i = 32'h0000FACE;
        advanceCycle;
        checkOutput("wr_done_busy", 32'(req1_busy), 32'h0);
        checkOutput("wr_done_err", 32'(req1_error), 32'h0);
        checkOutput("wr_done_data", req1_dataRead, 32'h0000FACE);
        wb_ack_i = 1'b0; wb_data_i = 32'h0; req1_enable = 1'b0;
        advanceCycle;

        // Bus error (with a simultaneous ack), then a clean transfer
        applyStimulus(0, 1'b1, 1'b0, 28'h0000123, 4'hF, 32'h0);
        advanceCycle;
        advanceCycle;
        wb_error_i = 1'b1; wb_ack_i = 1'b1; wb_data_i = 32'hFFFFFFFF;
        advanceCycle;
        checkOutput("err_flag", 32'(req0_error), 32'h1);
        checkOutput("err_data", req0_dataRead, 32'h0);
        checkOutput("err_busy", 32'(req0_busy), 32'h0);
        wb_error_i = 1'b0; wb_ack_i = 1'b0; wb_data_i = 32'h0;
        advanceCycle;
        checkOutput("err_cleared", 32'(req0_error), 32'h0);
        advanceCycle;
        wb_ack_i = 1'b1; wb_data_i = 32'h55AA55AA;
        advanceCycle;
        checkOutput("fast_busy", 32'(req0_busy), 32'h0);
        checkOutput("fast_data", req0_dataRead, 32'h55AA55AA);
        checkOutput("fast_err", 32'(req0_error), 32'h0);
        checkOutput("fast_cyc", 32'(wb_cyc_o), 32'h0);
        wb_ack_i = 1'b0; wb_data_i = 32'h0; req0_enable = 1'b0;
        advanceCycle;

        // Timeout after 8 cycles with no ack; late ack ignored
        applyStimulus(1, 1'b1, 1'b0, 28'h0000777, 4'hF, 32'h0);
        advanceCycle;
        for (int k = 1; k <= 8; k++) begin
            checkOutput($sformatf("to_cyc_c%0d", k), 32'(wb_cyc_o), 32'h1);
            advanceCycle;
        end
        checkOutput("to_cyc_dropped", 32'(wb_cyc_o), 32'h0);
        checkOutput("to_err", 32'(req1_error), 32'h1);
        checkOutput("to_data", req1_dataRead, 32'h0);
        checkOutput("to_busy", 32'(req1_busy), 32'h0);
        req1_enable = 1'b0;
        advanceCycle;
        wb_ack_i = 1'b1; wb_data_i = 32'h99999999;
        advanceCycle;
        checkOutput("late_ack_data", req1_dataRead, 32'h0);
        checkOutput("late_ack_err", 32'(req1_error), 32'h0);
        checkOutput("late_ack_cyc", 32'(wb_cyc_o), 32'h0);
        wb_ack_i = 1'b0; wb_data_i = 32'h0;

        // Reset during WAIT_ACK after requester 0 was last owner
        applyStimulus(0, 1'b1, 1'b0, 28'h0000300, 4'hF, 32'h0);
        advanceCycle;
        advanceCycle;
        wb_ack_i = 1'b1; wb_data_i = 32'h00000042;
        advanceCycle;
        checkOutput("pre_rst_data", req0_dataRead, 32'h00000042);
        wb_ack_i = 1'b0; wb_data_i = 32'h0;
        applyStimulus(1, 1'b1, 1'b1, 28'h0000400, 4'h1, 32'hAAAA5555);
        advanceCycle;
        advanceCycle;
        checkOutput("pre_rst_owner", 32'(wb_adr_o), 32'h400);
        advanceCycle;
        checkOutput("pre_rst_wait", 32'(wb_cyc_o), 32'h1);
        wb_rst_i = 1'b1;
        advanceCycle;
        checkOutput("mid_rst_cyc", 32'(wb_cyc_o), 32'h0);
        checkOutput("mid_rst_stb", 32'(wb_stb_o), 32'h0);
        checkOutput("mid_rst_we", 32'(wb_we_o), 32'h0);
        checkOutput("mid_rst_wdata", wb_data_o, 32'h0);
        checkOutput("mid_rst_dr0", req0_dataRead, 32'h0);
        checkOutput("mid_rst_err1", 32'(req1_error), 32'h0);
        wb_rst_i = 1'b0;
        advanceCycle;
        checkOutput("post_rst_tie_adr", 32'(wb_adr_o), 32'h300);
        checkOutput("post_rst_req1_busy", 32'(req1_busy), 32'h1);
        req0_enable = 1'b0; req1_enable = 1'b0;
        wb_rst_i = 1'b1;
        advanceCycle;
        wb_rst_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
